ahb_slave_data_mux: RTL

- Per-slave address/data-phase multiplexer that sits directly downstream of the per-slave arbiter.
- Consumes the arbiter's one-hot hgrant and routes the granted master's address/control to the slave in the address phase.
- Pipelines the owner index into the data phase, then routes hwdata to the slave and hrdata/hready/hresp back to the owning master.
- Produces hwait back to the arbiter; handles the AHB two-cycle ERROR response.

---
 rtl/ahb_slave_data_mux_pkg.sv | 39 +++
 rtl/ahb_slave_data_mux_onehot_enc.sv | 30 +++
 rtl/ahb_slave_data_mux.sv | 126 ++++++++++++
 3 files changed

// File: rtl/ahb_slave_data_mux_pkg.sv
// Shared AHB types, index-width helper and one-hot check for the per-slave data mux.
package ahb_slave_data_mux_pkg;

   typedef enum logic [1:0] {
      TR_IDLE   = 2'b00,
      TR_BUSY   = 2'b01,
      TR_NONSEQ = 2'b10,
      TR_SEQ    = 2'b11
   } htrans_type;

   typedef enum logic [2:0] {
      HB_SINGLE, HB_INCR, HB_WRAP4, HB_INCR4, HB_WRAP8, HB_INCR8, HB_WRAP16, HB_INCR16
   } hburst_type;

   typedef enum logic {
      HR_OKAY  = 1'b0,
      HR_ERROR = 1'b1
   } hresp_type;

   typedef enum logic [1:0] {
      ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2
   } mux_state_t;

   localparam int MAX_MASTERS = 32;

   // A single master still needs a 1-bit index signal; its value is always 0.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic onehot_is_valid(input logic [MAX_MASTERS-1:0] v);
      return (v != '0) && ((v & (v - 1'b1)) == '0);
   endfunction

   function automatic logic trans_active(input logic [1:0] t);
      return (t == TR_NONSEQ) || (t == TR_SEQ);
   endfunction

endpackage

// File: rtl/ahb_slave_data_mux_onehot_enc.sv
// One-hot to binary encoder with exactly-one-hot valid and multi-hot flags.
// Purely combinational.
module ahb_onehot_enc
   import ahb_slave_data_mux_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = idx_width(N)
) (
   input  logic [N-1:0]  i_onehot,
   output logic [IW-1:0] o_idx,
   output logic          o_vld,
   output logic          o_multi
);

   logic [MAX_MASTERS-1:0] w_ext;

   assign w_ext = MAX_MASTERS'(i_onehot);

   // OR of set-bit positions: exact whenever the input is one-hot.
   always_comb begin
      o_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (i_onehot[i]) o_idx = o_idx | IW'(i);
      end
   end

   assign o_vld   = onehot_is_valid(w_ext);
   assign o_multi = (w_ext != '0) && !o_vld;

endmodule

// File: rtl/ahb_slave_data_mux.sv
// Per-slave AHB address/data-phase mux: routes the granted master to the slave,
// carries ownership into the data phase and returns ready/resp/rdata to the owner.
module ahb_slave_data_mux
   import ahb_slave_data_mux_pkg::*;
#(
   parameter int MASTER_NUM = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                             hclk,
   input  logic                             hreset_n,
   input  logic [MASTER_NUM-1:0]            hgrant,
   input  logic [MASTER_NUM*ADDR_WIDTH-1:0] m_haddr,
   input  logic [MASTER_NUM*2-1:0]          m_htrans,
   input  logic [MASTER_NUM-1:0]            m_hwrite,
   input  logic [MASTER_NUM*3-1:0]          m_hsize,
   input  logic [MASTER_NUM*3-1:0]          m_hburst,
   input  logic [MASTER_NUM*DATA_WIDTH-1:0] m_hwdata,
   output logic [MASTER_NUM-1:0]            m_hready,
   output logic [MASTER_NUM-1:0]            m_hresp,
   output logic [DATA_WIDTH-1:0]            m_hrdata,
   output logic                             s_hsel,
   output logic [ADDR_WIDTH-1:0]            s_haddr,
   output logic [1:0]                       s_htrans,
   output logic                             s_hwrite,
   output logic [2:0]                       s_hsize,
   output logic [2:0]                       s_hburst,
   output logic [DATA_WIDTH-1:0]            s_hwdata,
   input  logic                             s_hreadyout,
   input  logic                             s_hresp,
   input  logic [DATA_WIDTH-1:0]            s_hrdata,
   output logic                             hwait,
   output logic                             grant_err
);

   localparam int IW = idx_width(MASTER_NUM);

   logic [IW-1:0] w_addr_idx;
   logic          w_addr_vld;
   logic          w_multi;
   logic [1:0]    w_sel_trans;
   logic          w_err_st;
   logic          w_xfer;

   mux_state_t    r_state;
   logic [IW-1:0] r_dp_idx;
   logic          r_dp_vld;
   logic          r_grant_err;

   ahb_onehot_enc #(.N(MASTER_NUM), .IW(IW)) u_enc (
      .i_onehot (hgrant),
      .o_idx    (w_addr_idx),
      .o_vld    (w_addr_vld),
      .o_multi  (w_multi)
   );

   assign w_sel_trans = m_htrans[int'(w_addr_idx)*2 +: 2];
   assign w_err_st    = (r_state == ST_ERR1) || (r_state == ST_ERR2);
   // Address phases presented during an error response are cancelled, never accepted.
   assign w_xfer      = w_addr_vld && !w_err_st && trans_active(w_sel_trans);

   always_comb begin
      s_hsel   = 1'b0;
      s_htrans = TR_IDLE;
      s_haddr  = '0;
      s_hwrite = 1'b0;
      s_hsize  = '0;
      s_hburst = '0;
      if (w_addr_vld) begin
         s_hsel   = 1'b1;
         s_htrans = w_err_st ? TR_IDLE : w_sel_trans;
         s_haddr  = m_haddr[int'(w_addr_idx)*ADDR_WIDTH +: ADDR_WIDTH];
         s_hwrite = m_hwrite[w_addr_idx];
         s_hsize  = m_hsize[int'(w_addr_idx)*3 +: 3];
         s_hburst = m_hburst[int'(w_addr_idx)*3 +: 3];
      end
   end

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         r_state     <= ST_IDLE;
         r_dp_idx    <= '0;
         r_dp_vld    <= 1'b0;
         r_grant_err <= 1'b0;
      end else begin
         if (w_multi) r_grant_err <= 1'b1;
         if (s_hreadyout) begin
            r_dp_idx <= w_addr_idx;
            r_dp_vld <= w_xfer;
         end
         case (r_state)
            ST_IDLE: if (s_hreadyout && w_xfer) r_state <= ST_DATA;
            ST_DATA: begin
               if (s_hreadyout)  r_state <= w_xfer ? ST_DATA : ST_IDLE;
               else if (s_hresp) r_state <= ST_ERR1;
            end
            ST_ERR1: if (s_hreadyout) r_state <= ST_ERR2;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign s_hwdata  = r_dp_vld ? m_hwdata[int'(r_dp_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign m_hrdata  = s_hrdata;
   assign hwait     = r_dp_vld & ~s_hreadyout;
   assign grant_err = r_grant_err;

   // The address-phase path is withheld during ERR1/ERR2 so the granted requester stalls.
   always_comb begin
      m_hready = '0;
      m_hresp  = '0;
      for (int i = 0; i < MASTER_NUM; i++) begin
         if (r_dp_vld && (r_dp_idx == IW'(i))) begin
            m_hready[i] = s_hreadyout;
            m_hresp[i]  = s_hresp;
         end else if (w_addr_vld && !w_err_st && (w_addr_idx == IW'(i))) begin
            m_hready[i] = s_hreadyout;
            m_hresp[i]  = HR_OKAY;
         end else begin
            m_hready[i] = !trans_active(m_htrans[i*2 +: 2]);
            m_hresp[i]  = HR_OKAY;
         end
      end
   end

endmodule
